// File: rtl/rv32_types.sv
// Shared types and opcode constants for the RV32I decode stage and its neighbours.
package rv32_types;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
    } alu_op_t;

    typedef enum logic [1:0] {MemNone, MemLoad, MemStore} mem_op_t;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_t;

    typedef struct packed {
        logic        do_jump;
        logic [31:0] jump_addr;
    } jump_request_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        generate_nop;
    } fetch_decode_buffer_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [31:0] imm;
        alu_op_t     alu_op;
        logic        alu_use_imm;
        logic        alu_use_pc;
        mem_op_t     mem_op;
    } decode_exec_buffer_t;

    // Only register-register OP uses instr[30] to select SUB; OP-IMM uses it for SRAI only.
    function automatic alu_op_t alu_from_funct(logic [2:0] funct3, logic bit30, logic is_op);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (is_op && bit30) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = bit30 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediates from the instruction word.
module rv32_imm_gen
    import rv32_types::*;
(
    input  logic [31:0] instr,
    input  imm_type_t   imm_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (imm_type)
            ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU:    imm = {instr[31:12], 12'd0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: decodes the fetched word, detects load-use hazards and registers
// the result for execute; a word arriving during stop/stall is held until it can advance.
module rv32_decode_stage
    import rv32_types::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stop,
    input  jump_request_t        jump_request,
    input  fetch_decode_buffer_t fetch_decode_buff,
    input  logic [31:0]          instr,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    input  logic [31:0]          rs1_data,
    input  logic [31:0]          rs2_data,
    output logic                 stall,
    output decode_exec_buffer_t  decode_exec_buff
);

    decode_exec_buffer_t dexec_q, dexec_d, dec;
    logic                hold_valid_q, hold_valid_d;
    logic [31:0]         hold_instr_q, hold_instr_d;

    logic [31:0] eff_instr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic        illegal, uses_rs1, uses_rs2, writes_rd, use_imm, use_pc, hazard, do_jump;
    alu_op_t     alu_op;
    mem_op_t     mem_op;
    imm_type_t   imm_type;
    logic [31:0] imm;
    logic        unused_jump_addr;

    assign unused_jump_addr = ^jump_request.jump_addr;
    assign do_jump   = jump_request.do_jump;
    assign eff_instr = hold_valid_q ? hold_instr_q : instr;
    assign opcode    = eff_instr[6:0];
    assign funct3    = eff_instr[14:12];
    assign funct7    = eff_instr[31:25];
    assign rd_f      = eff_instr[11:7];
    assign rs1_f     = eff_instr[19:15];
    assign rs2_f     = eff_instr[24:20];
    assign rs1_addr  = rs1_f;
    assign rs2_addr  = rs2_f;

    rv32_imm_gen u_imm_gen (
        .instr    (eff_instr),
        .imm_type (imm_type),
        .imm      (imm)
    );

    always_comb begin
        illegal   = 1'b0;
        imm_type  = ImmNone;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        use_imm   = 1'b0;
        use_pc    = 1'b0;
        alu_op    = AluAdd;
        mem_op    = MemNone;
        if (eff_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OpcLui: begin
                    imm_type = ImmU; writes_rd = 1'b1; use_imm = 1'b1; alu_op = AluPassB;
                end
                OpcAuipc: begin
                    imm_type = ImmU; writes_rd = 1'b1; use_imm = 1'b1; use_pc = 1'b1;
                end
                OpcJal: begin
                    imm_type = ImmJ; writes_rd = 1'b1; use_imm = 1'b1; use_pc = 1'b1;
                end
                OpcJalr: begin
                    imm_type = ImmI; writes_rd = 1'b1; uses_rs1 = 1'b1; use_imm = 1'b1;
                    illegal  = (funct3 != 3'b000);
                end
                OpcBranch: begin
                    imm_type = ImmB; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                    use_imm  = 1'b1; use_pc = 1'b1;
                    illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
                end
                OpcLoad: begin
                    imm_type = ImmI; writes_rd = 1'b1; uses_rs1 = 1'b1; use_imm = 1'b1;
                    mem_op   = MemLoad;
                    illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                end
                OpcStore: begin
                    imm_type = ImmS; uses_rs1 = 1'b1; uses_rs2 = 1'b1; use_imm = 1'b1;
                    mem_op   = MemStore;
                    illegal  = (funct3 > 3'b010);
                end
                OpcOpImm: begin
                    imm_type  = ImmI; writes_rd = 1'b1; uses_rs1 = 1'b1; use_imm = 1'b1;
                    alu_op    = alu_from_funct(funct3, eff_instr[30], 1'b0);
                    if (funct3 == 3'b001) illegal = (funct7 != 7'b0000000);
                    if (funct3 == 3'b101) illegal = (funct7 != 7'b0000000) &&
                                                    (funct7 != 7'b0100000);
                end
                OpcOp: begin
                    writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                    alu_op    = alu_from_funct(funct3, eff_instr[30], 1'b1);
                    illegal   = (funct7 != 7'b0000000) &&
                                !((funct7 == 7'b0100000) &&
                                  ((funct3 == 3'b000) || (funct3 == 3'b101)));
                end
                OpcMiscMem: illegal = (funct3 != 3'b000);
                OpcSystem: begin
                    imm_type = ImmI;
                    illegal  = (eff_instr != 32'h0000_0073) && (eff_instr != 32'h0010_0073);
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Illegal entries carry only pc and the illegal flag so execute never acts on them.
    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.illegal = illegal;
        dec.pc      = fetch_decode_buff.pc;
        if (!illegal) begin
            dec.opcode      = opcode;
            dec.funct3      = funct3;
            dec.rd          = writes_rd ? rd_f : 5'd0;
            dec.rs1         = uses_rs1 ? rs1_f : 5'd0;
            dec.rs2         = uses_rs2 ? rs2_f : 5'd0;
            dec.rs1_value   = (uses_rs1 && rs1_f != 5'd0) ? rs1_data : 32'd0;
            dec.rs2_value   = (uses_rs2 && rs2_f != 5'd0) ? rs2_data : 32'd0;
            dec.imm         = imm;
            dec.alu_op      = alu_op;
            dec.alu_use_imm = use_imm;
            dec.alu_use_pc  = use_pc;
            dec.mem_op      = mem_op;
        end
    end

    always_comb begin
        hazard = dexec_q.valid && (dexec_q.mem_op == MemLoad) && (dexec_q.rd != 5'd0) &&
                 !illegal &&
                 ((uses_rs1 && dexec_q.rd == rs1_f) || (uses_rs2 && dexec_q.rd == rs2_f));
        stall  = hazard && !fetch_decode_buff.generate_nop && !stop && !do_jump;
    end

    always_comb begin
        dexec_d = dexec_q;
        if (do_jump) begin
            dexec_d = '0;
        end else if (stop) begin
            dexec_d = dexec_q;
        end else if (stall || fetch_decode_buff.generate_nop) begin
            dexec_d = '0;
        end else begin
            dexec_d = dec;
        end
    end

    // The bus word is only valid in its first cycle, so capture it if it cannot advance.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        if (do_jump) begin
            hold_valid_d = 1'b0;
        end else if (!hold_valid_q && !fetch_decode_buff.generate_nop && (stop || stall)) begin
            hold_valid_d = 1'b1;
            hold_instr_d = instr;
        end else if (hold_valid_q && !stop && !stall) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dexec_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= 32'd0;
        end else begin
            dexec_q      <= dexec_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign decode_exec_buff = dexec_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Self-checking bench for rv32_decode_stage: vector table plus hazard/stop/jump/reset sequences.
module tb_rv32_decode_stage;
    import rv32_types::*;

    logic                 clk;
    logic                 reset;
    logic                 stop;
    jump_request_t        jr;
    fetch_decode_buffer_t fdb;
    logic [31:0]          instr;
    logic [4:0]           rs1_addr, rs2_addr;
    logic [31:0]          rs1_data, rs2_data;
    logic                 stall;
    decode_exec_buffer_t  dout;

    rv32_decode_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stop              (stop),
        .jump_request      (jr),
        .fetch_decode_buff (fdb),
        .instr             (instr),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .stall             (stall),
        .decode_exec_buff  (dout)
    );

    // Register file returns a recognisable value per address, x0 included.
    assign rs1_data = 32'hA000_0000 | {27'd0, rs1_addr};
    assign rs2_data = 32'hB000_0000 | {27'd0, rs2_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        illegal;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        mem_op_t     mem_op;
        alu_op_t     alu_op;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[18];
    int   checks = 0;
    int   failures = 0;
    logic stop_s, jump_s, reset_s;

    function automatic vec_t mk(logic [31:0] ins, logic [31:0] pc, logic ill, logic [4:0] rd,
                                logic [31:0] imm, logic [31:0] r1, logic [31:0] r2,
                                mem_op_t mem, alu_op_t alu);
        vec_t v;
        v.instr       = ins;
        v.e.pc        = pc;
        v.e.illegal   = ill;
        v.e.rd        = rd;
        v.e.imm       = imm;
        v.e.rs1_value = r1;
        v.e.rs2_value = r2;
        v.e.mem_op    = mem;
        v.e.alu_op    = alu;
        return v;
    endfunction

    task automatic check_bit(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Scoreboard: compare every newly loaded valid output against the queue head.
    task automatic monitor_check();
        exp_t e;
        if (!reset_s && !(stop_s && !jump_s) && dout.valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue actual_pc=%h required=none", dout.pc);
            end else begin
                e = exp_q.pop_front();
                if (dout.pc !== e.pc || dout.illegal !== e.illegal || dout.rd !== e.rd ||
                    dout.imm !== e.imm || dout.rs1_value !== e.rs1_value ||
                    dout.rs2_value !== e.rs2_value || dout.mem_op !== e.mem_op ||
                    dout.alu_op !== e.alu_op) begin
                    failures++;
                    $display("FAIL issue_pc_%h actual pc=%h ill=%b rd=%0d imm=%h r1=%h r2=%h mem=%0d alu=%0d required pc=%h ill=%b rd=%0d imm=%h r1=%h r2=%h mem=%0d alu=%0d",
                             e.pc, dout.pc, dout.illegal, dout.rd, dout.imm, dout.rs1_value,
                             dout.rs2_value, int'(dout.mem_op), int'(dout.alu_op), e.pc,
                             e.illegal, e.rd, e.imm, e.rs1_value, e.rs2_value, int'(e.mem_op),
                             int'(e.alu_op));
                end
            end
        end
    endtask

    // Called at a falling edge: run through the next rising edge and return at the next fall.
    task automatic cycle();
        @(posedge clk);
        stop_s  = stop;
        jump_s  = jr.do_jump;
        reset_s = reset;
        #1;
        monitor_check();
        @(negedge clk);
    endtask

    task automatic present(logic [31:0] pc, logic [31:0] ins);
        fdb.pc           = pc;
        fdb.generate_nop = 1'b0;
        instr            = ins;
    endtask

    initial begin
        vecs[0]  = mk(32'hFFF0_0093, 32'h100, 0, 1,  32'hFFFF_FFFF, 0, 0, MemNone, AluAdd);
        vecs[1]  = mk(32'h1234_51B7, 32'h104, 0, 3,  32'h1234_5000, 0, 0, MemNone, AluPassB);
        vecs[2]  = mk(32'h0000_1217, 32'h108, 0, 4,  32'h0000_1000, 0, 0, MemNone, AluAdd);
        vecs[3]  = mk(32'h0080_00EF, 32'h10C, 0, 1,  32'h0000_0008, 0, 0, MemNone, AluAdd);
        vecs[4]  = mk(32'h0000_8067, 32'h110, 0, 0,  32'h0, 32'hA000_0001, 0, MemNone, AluAdd);
        vecs[5]  = mk(32'h0000_007F, 32'h114, 1, 0,  32'h0, 0, 0, MemNone, AluAdd);
        vecs[6]  = mk(32'hFE20_8EE3, 32'h118, 0, 0,  32'hFFFF_FFFC, 32'hA000_0001,
                      32'hB000_0002, MemNone, AluAdd);
        vecs[7]  = mk(32'h0020_A223, 32'h11C, 0, 0,  32'h4, 32'hA000_0001, 32'hB000_0002,
                      MemStore, AluAdd);
        vecs[8]  = mk(32'h4020_83B3, 32'h120, 0, 7,  32'h0, 32'hA000_0001, 32'hB000_0002,
                      MemNone, AluSub);
        vecs[9]  = mk(32'h4030_D413, 32'h124, 0, 8,  32'h403, 32'hA000_0001, 0, MemNone, AluSra);
        vecs[10] = mk(32'h0020_04B3, 32'h128, 0, 9,  32'h0, 0, 32'hB000_0002, MemNone, AluAdd);
        vecs[11] = mk(32'hFFF1_8503, 32'h12C, 0, 10, 32'hFFFF_FFFF, 32'hA000_0003, 0,
                      MemLoad, AluAdd);
        vecs[12] = mk(32'h0000_0073, 32'h130, 0, 0,  32'h0, 0, 0, MemNone, AluAdd);
        vecs[13] = mk(32'h0010_0073, 32'h134, 0, 0,  32'h1, 0, 0, MemNone, AluAdd);
        vecs[14] = mk(32'h0FF0_000F, 32'h138, 0, 0,  32'h0, 0, 0, MemNone, AluAdd);
        vecs[15] = mk(32'h0220_8333, 32'h13C, 1, 0,  32'h0, 0, 0, MemNone, AluAdd);
        vecs[16] = mk(32'hFFF0_0090, 32'h140, 1, 0,  32'h0, 0, 0, MemNone, AluAdd);
        vecs[17] = mk(32'hFE20_AEE3, 32'h144, 1, 0,  32'h0, 0, 0, MemNone, AluAdd);

        reset = 1'b1;
        stop  = 1'b0;
        jr    = '0;
        fdb   = '0;
        fdb.generate_nop = 1'b1;
        instr = 32'd0;
        stop_s = 1'b0; jump_s = 1'b0; reset_s = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL reset_out actual=%h required=0", dout);
        end
        check_bit("reset_stall", stall, 1'b0);
        reset = 1'b0;
        cycle();

        // Back-to-back table, one instruction per cycle.
        for (int i = 0; i < 18; i++) begin
            present(vecs[i].e.pc, vecs[i].instr);
            exp_q.push_back(vecs[i].e);
            cycle();
        end
        fdb.generate_nop = 1'b1;
        cycle();
        check_bit("nop_bubble_valid", dout.valid, 1'b0);

        // Load-use: one stall cycle, one bubble, then the add from the held word.
        present(32'h300, 32'h0001_2283);
        exp_q.push_back(mk(0, 32'h300, 0, 5, 0, 32'hA000_0002, 0, MemLoad, AluAdd).e);
        cycle();
        present(32'h304, 32'h0012_8333);
        #1 check_bit("loaduse_stall", stall, 1'b1);
        exp_q.push_back(mk(0, 32'h304, 0, 6, 0, 32'hA000_0005, 32'hB000_0001,
                           MemNone, AluAdd).e);
        cycle();
        instr = 32'hDEAD_BEEF;
        #1 check_bit("loaduse_stall_drop", stall, 1'b0);
        check_bit("loaduse_bubble", dout.valid, 1'b0);
        cycle();
        fdb.generate_nop = 1'b1;
        cycle();

        // Stop for three cycles while the bus word changes.
        present(32'h200, 32'h0050_0593);
        stop = 1'b1;
        exp_q.push_back(mk(0, 32'h200, 0, 11, 32'h5, 0, 0, MemNone, AluAdd).e);
        cycle();
        instr = 32'hDEAD_BEEF;
        cycle();
        cycle();
        stop = 1'b0;
        cycle();
        fdb.generate_nop = 1'b1;
        cycle();

        // Jump during stop with a held word; stall suppressed under stop and jump.
        present(32'h500, 32'h0001_2283);
        exp_q.push_back(mk(0, 32'h500, 0, 5, 0, 32'hA000_0002, 0, MemLoad, AluAdd).e);
        cycle();
        present(32'h504, 32'h0012_8333);
        stop = 1'b1;
        #1 check_bit("stop_no_stall", stall, 1'b0);
        cycle();
        instr = 32'hDEAD_BEEF;
        jr.do_jump = 1'b1;
        #1 check_bit("jump_no_stall", stall, 1'b0);
        cycle();
        check_bit("jump_bubble", dout.valid, 1'b0);
        jr.do_jump = 1'b0;
        stop = 1'b0;
        present(32'h600, 32'h0070_0613);
        exp_q.push_back(mk(0, 32'h600, 0, 12, 32'h7, 0, 0, MemNone, AluAdd).e);
        cycle();
        fdb.generate_nop = 1'b1;
        cycle();

        // Reset while a stalled word is held; afterwards decode uses the live bus word.
        present(32'h700, 32'h0001_2283);
        exp_q.push_back(mk(0, 32'h700, 0, 5, 0, 32'hA000_0002, 0, MemLoad, AluAdd).e);
        cycle();
        present(32'h704, 32'h0012_8333);
        #1 check_bit("reset_seq_stall", stall, 1'b1);
        cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL midstall_reset_out actual=%h required=0", dout);
        end
        check_bit("midstall_reset_stall", stall, 1'b0);
        cycle();
        check_bit("reset_held_stall", stall, 1'b0);
        reset = 1'b0;
        present(32'h800, 32'h0090_0693);
        exp_q.push_back(mk(0, 32'h800, 0, 13, 32'h9, 0, 0, MemNone, AluAdd).e);
        cycle();
        fdb.generate_nop = 1'b1;
        cycle();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
